// File: rtl/fp_pkg.sv
// Shared types and constants for the multi-cycle single-precision adder.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int EXT_W  = 27;
    localparam int BIAS   = 127;
    localparam int SH_W   = 6;
    localparam int XEXP_W = 10;

    localparam logic [31:0]     QNAN    = 32'h7FC0_0000;
    localparam logic [SH_W-1:0] SH_FULL = SH_W'(EXT_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;
endpackage

// File: rtl/fp_shift_unit.sv
// 27-bit barrel shifter shared by alignment (right, with sticky) and normalisation (left).
module fp_shift_unit
    import fp_pkg::*;
(
    input  logic [EXT_W-1:0] data,
    input  logic [SH_W-1:0]  amount,
    input  logic             dir,
    output logic [EXT_W-1:0] shifted,
    output logic             sticky
);
    logic [EXT_W-1:0] lost_mask;

    always_comb begin
        shifted   = '0;
        sticky    = 1'b0;
        lost_mask = '0;
        if (dir) begin
            shifted = data << amount;
        end else begin
            shifted   = data >> amount;
            lost_mask = (amount >= SH_FULL) ? '1 : ~({EXT_W{1'b1}} << amount);
            sticky    = |(data & lost_mask);
        end
    end
endmodule

// File: rtl/fp_add_sequencer.sv
// Sequential IEEE-754 single-precision add/subtract: one pipeline step per FSM state,
// round-to-nearest-even, no denormals, any exp-255 operand yields a quiet NaN.
module fp_add_sequencer #(
    parameter int ALIGN_LIMIT = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    import fp_pkg::*;

    localparam logic [EXP_W-1:0] LIMIT_E = EXP_W'(ALIGN_LIMIT);

    state_t                    state;
    logic [31:0]               a_r, b_r;
    logic                      op_r;
    logic                      sign_x, sign_y, sign_r, sub_r, nan_f, zero_f;
    logic [EXP_W-1:0]          exp_x, exp_y;
    logic [EXT_W-1:0]          man_x, man_y, m_big, m_small, mant_n;
    logic [EXT_W:0]            sum;
    logic signed [XEXP_W-1:0]  exp_r;

    logic                      x_ge_y, collapse;
    logic [EXP_W-1:0]          exp_diff;
    logic [EXT_W-1:0]          man_small, sh_data, sh_out;
    logic [SH_W-1:0]           align_amt, sh_amt, lzc;
    logic                      sh_dir, sh_sticky;
    logic signed [XEXP_W-1:0]  lzc_ext, exp_fin;
    logic                      round_up;
    logic [MAN_W+1:0]          rounded;
    logic [31:0]               packed_res;

    always_comb begin
        x_ge_y    = {exp_x, man_x} >= {exp_y, man_y};
        exp_diff  = x_ge_y ? exp_x - exp_y : exp_y - exp_x;
        man_small = x_ge_y ? man_y : man_x;
        collapse  = exp_diff >= LIMIT_E;
        align_amt = (exp_diff > 8'd63) ? '1 : exp_diff[SH_W-1:0];
    end

    always_comb begin
        lzc = '0;
        for (int unsigned i = 0; i < EXT_W; i++) begin
            if (sum[i]) lzc = SH_W'(EXT_W - 1 - i);
        end
        lzc_ext = {{(XEXP_W-SH_W){1'b0}}, lzc};
    end

    // ALIGN drives the shifter rightwards; NORM reuses it for the left normalise.
    always_comb begin
        sh_data = man_small;
        sh_amt  = align_amt;
        sh_dir  = 1'b0;
        if (state == S_NORM) begin
            sh_data = sum[EXT_W-1:0];
            sh_amt  = lzc;
            sh_dir  = 1'b1;
        end
    end

    fp_shift_unit u_shift (
        .data    (sh_data),
        .amount  (sh_amt),
        .dir     (sh_dir),
        .shifted (sh_out),
        .sticky  (sh_sticky)
    );

    always_comb begin
        round_up = mant_n[2] & (mant_n[1] | mant_n[0] | mant_n[3]);
        rounded  = {1'b0, mant_n[EXT_W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
        exp_fin  = exp_r + (rounded[MAN_W+1] ? 10'sd1 : 10'sd0);
        if (nan_f)
            packed_res = QNAN;
        else if (zero_f)
            packed_res = '0;
        else if (exp_fin >= 10'sd255)
            packed_res = {sign_r, 8'hFF, 23'd0};
        else if (exp_fin <= 10'sd0)
            packed_res = {sign_r, 31'd0};
        else
            packed_res = {sign_r, exp_fin[EXP_W-1:0],
                          rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= 1'b0;
            sign_x  <= 1'b0;
            sign_y  <= 1'b0;
            sign_r  <= 1'b0;
            sub_r   <= 1'b0;
            nan_f   <= 1'b0;
            zero_f  <= 1'b0;
            exp_x   <= '0;
            exp_y   <= '0;
            man_x   <= '0;
            man_y   <= '0;
            m_big   <= '0;
            m_small <= '0;
            mant_n  <= '0;
            sum     <= '0;
            exp_r   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
                        busy  <= 1'b1;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_x <= a_r[31];
                    sign_y <= b_r[31] ^ op_r;
                    exp_x  <= a_r[30:23];
                    exp_y  <= b_r[30:23];
                    man_x  <= (a_r[30:23] == '0) ? '0 : {1'b1, a_r[22:0], 3'b000};
                    man_y  <= (b_r[30:23] == '0) ? '0 : {1'b1, b_r[22:0], 3'b000};
                    nan_f  <= (&a_r[30:23]) | (&b_r[30:23]);
                    state  <= S_ALIGN;
                end
                S_ALIGN: begin
                    sign_r  <= x_ge_y ? sign_x : sign_y;
                    sub_r   <= sign_x ^ sign_y;
                    exp_r   <= {2'b00, x_ge_y ? exp_x : exp_y};
                    m_big   <= x_ge_y ? man_x : man_y;
                    m_small <= collapse ? {{(EXT_W-1){1'b0}}, |man_small}
                                        : {sh_out[EXT_W-1:1], sh_out[0] | sh_sticky};
                    state   <= S_ADD;
                end
                S_ADD: begin
                    sum   <= sub_r ? {1'b0, m_big} - {1'b0, m_small}
                                   : {1'b0, m_big} + {1'b0, m_small};
                    state <= S_NORM;
                end
                S_NORM: begin
                    zero_f <= (sum == '0);
                    if (sum[EXT_W]) begin
                        mant_n <= {sum[EXT_W:2], sum[1] | sum[0]};
                        exp_r  <= exp_r + 10'sd1;
                    end else begin
                        mant_n <= sh_out;
                        exp_r  <= exp_r - lzc_ext;
                    end
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    result <= packed_res;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer: stimulus pushes expected sums, a monitor pops on done.
module tb_fp_add_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] exp_res;
        int unsigned t0;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
    } txn_t;
    txn_t sb[$];

    fp_add_sequencer #(.ALIGN_LIMIT(27)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Exact integer reference: align in wide arithmetic, then round-to-nearest-even.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic   sx, sy, st;
        int     ex, ey, et, d, sc, p, e, sh;
        longint mx, my, mt, big, sml, r, q, rem, half;
        sx = x[31];
        sy = y[31] ^ sub;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if (ex == 255 || ey == 255) return 32'h7FC0_0000;
        mx = (ex == 0) ? 64'd0 : {40'd0, 1'b1, x[22:0]};
        my = (ey == 0) ? 64'd0 : {40'd0, 1'b1, y[22:0]};
        if (ey > ex || (ey == ex && my > mx)) begin
            st = sx; sx = sy; sy = st;
            et = ex; ex = ey; ey = et;
            mt = mx; mx = my; my = mt;
        end
        if (mx == 0) return 32'h0;
        d   = ex - ey;
        sc  = (d > 30) ? 30 : d;
        big = mx << sc;
        sml = (d > 30) ? ((my != 0) ? 64'd1 : 64'd0) : my;
        r   = (sx == sy) ? big + sml : big - sml;
        if (r == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 63; i++) if (r[i]) p = i;
        e = ex + p - 23 - sc;
        if (p > 23) begin
            sh   = p - 23;
            q    = r >> sh;
            rem  = r - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end else begin
            q = r << (23 - p);
        end
        if (e >= 255) return {sx, 8'hFF, 23'd0};
        if (e <= 0) return {sx, 31'd0};
        return {sx, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp(input int base);
        int          e;
        logic [22:0] f;
        logic        s;
        e = base + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        case ($urandom_range(0, 19))
            0: e = 0;
            1: e = 255;
            2: e = 254;
            3: e = 1;
            default: ;
        endcase
        f = 23'($urandom);
        if ($urandom_range(0, 7) == 0) f = '0;
        else if ($urandom_range(0, 7) == 0) f = '1;
        s = 1'($urandom);
        return {s, 8'(e), f};
    endfunction

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                         input logic [31:0] expv, input bit track);
        int unsigned waited;
        txn_t t;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: busy still %b after %0d cycles, expected 0", busy, waited);
        end
        a     = ta;
        b     = tb_v;
        op    = top;
        start = 1'b1;
        if (track) begin
            t.exp_res = expv;
            t.t0      = cyc;
            t.a       = ta;
            t.b       = tb_v;
            t.op      = top;
            sb.push_back(t);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: result %h, expected no done pulse", result);
                end else begin
                    t = sb.pop_front();
                    check($sformatf("result a=%h b=%h op=%0d", t.a, t.b, t.op), result, t.exp_res);
                    check("latency", 32'(cyc - t.t0), 32'd6);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rop;
        int          base;
        int unsigned waited;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'h0);
        @(negedge clk) reset = 1'b0;

        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b1);
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b1);
        issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b1);
        issue(32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, 1'b1);
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1);
        rb = $urandom;
        issue(32'h7F80_0000, rb, 1'b0, 32'h7FC0_0000, 1'b1);
        issue(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1);
        issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b1);

        // second start lands in ALIGN and must be dropped
        issue(32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a     = 32'h4120_0000;
        b     = 32'h4120_0000;
        op    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        // abort an operation while it sits in NORM
        issue(32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", result, 32'h0);
        @(negedge clk) reset = 1'b0;
        issue(32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4040_0000, 1'b1);

        for (int unsigned n = 0; n < 300; n++) begin
            base = int'($urandom_range(1, 254));
            ra   = rand_fp(base);
            rb   = rand_fp(base);
            rop  = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            issue(ra, rb, rop, ref_add(ra, rb, rop), 1'b1);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_add_sequencer.md
FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 SHALL have parameter ALIGN_LIMIT, default 27: exponent difference at or above which the smaller mantissa collapses to a sticky bit only.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  1  0 = a+b, 1 = a-b; captured with start.
REQ-006 SHALL have port a  input  32  IEEE-754 single operand; captured with start.
REQ-007 SHALL have port b  input  32  IEEE-754 single operand; captured with start.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse in DONE state.
REQ-010 SHALL have port result  output  32  sum; valid from DONE, held until next accepted start.

Function
REQ-011 SHALL implement FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE, one cycle per state, no stalls.
REQ-012 SHALL accept start only when in IDLE; start while busy is ignored, no queuing.
REQ-013 SHALL assert done exactly 6 cycles after the accepting edge; back-to-back start in the cycle after DONE is accepted.
REQ-014 UNPACK: split sign/exponent/mantissa, insert hidden 1; exp 0 operand treated as signed zero (no denormals); op=1 inverts b sign.
REQ-015 UNPACK: any operand with exp 255 forces result 0x7FC00000 at DONE, bypassing arithmetic.
REQ-016 ALIGN: swap so the larger magnitude is first; right-shift smaller 27-bit mantissa (1.23 + G,R,S) by exponent difference; shifted-out bits OR into S.
REQ-017 ALIGN: difference >= ALIGN_LIMIT yields smaller mantissa = 0 with S = 1 if its significand was nonzero.
REQ-018 ADD: 28-bit add when signs equal, subtract (larger minus smaller) otherwise; result sign = larger operand sign.
REQ-019 NORM: carry-out -> right shift 1 (sticky preserved), exponent +1; else left shift by leading-zero count, exponent decremented by same.
REQ-020 NORM: zero sum -> result +0 (0x00000000), regardless of operand signs.
REQ-021 ROUND: round-to-nearest-even using G,R,S; mantissa overflow from rounding renormalises, exponent +1.
REQ-022 Exponent >= 255 after NORM/ROUND -> signed infinity (exp 255, mantissa 0); exponent <= 0 -> signed zero.
REQ-023 Internal exponent arithmetic SHALL be 10-bit signed to detect overflow/underflow without wrap.

Reset
REQ-024 reset SHALL force state IDLE, busy 0, done 0, result 0x00000000, all internal registers 0, immediately and independent of clk.
REQ-025 reset asserted mid-operation SHALL abort it; no done pulse follows; first start after deassertion is accepted normally.

Structure
REQ-026 Package fp_pkg SHALL hold state enum, field widths (EXP_W 8, MAN_W 23, EXT_W 27), BIAS 127, QNAN 0x7FC00000.
REQ-027 One sub-module fp_shift_unit SHALL provide 27-bit shift, direction input (0 right, 1 left), sticky output; ALIGN and NORM share it.
REQ-028 Leading-zero count SHALL be combinational inside fp_add_sequencer.

Verification
REQ-029 a=0x3F800000, b=0x3F800000, op=0 -> done 6 cycles later, result 0x40000000.
REQ-030 a=0x3F800000, b=0x3F800000, op=1 -> result 0x00000000.
REQ-031 a=0x3F800000, b=0x33800000 (exact tie) -> 0x3F800000; b=0x33800001 -> 0x3F800001.
REQ-032 a=b=0x7F7FFFFF, op=0 -> 0x7F800000; a=0x7F800000, any b -> 0x7FC00000.
REQ-033 start pulsed during ALIGN with new operands -> ignored, only one done, result from first operands.
REQ-034 reset asserted during NORM -> busy/done/result 0 same cycle; next start completes correctly in 6 cycles.
